rob: RTL and testbench

//  Reorder buffer: circular queue of in-flight instructions. Allocates one ROB tag per dispatched instruction
//  and drives it to the map table. Captures CDB results and retires completed entries in order, at most one per cycle.

---
 rtl/rob_pkg.sv | 71 +++++++
 rtl/rob.sv | 134 +++++++++++++
 tb/tb_rob.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared ROB types and sizing: entry record plus the packets exchanged with
// dispatch, the CDB, the map table, the RS and the architectural regfile.
// Tag 0 means "no tag", so entry i always carries tag i+1.
package rob_pkg;

    localparam int ROB_SZ    = 8;
    localparam int ROB_TAG_W = $clog2(ROB_SZ + 1);
    localparam int ROB_PTR_W = $clog2(ROB_SZ);
    localparam int ROB_CNT_W = $clog2(ROB_SZ + 1);
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic                 has_dest;
        logic [REG_IDX_W-1:0] dest_reg_idx;
    } DP_PACKET;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      value;
    } CDB_PACKET;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 t_plus;
    } MAP_PACKET;

    typedef struct packed {
        MAP_PACKET map_packet_a;
        MAP_PACKET map_packet_b;
    } MAP_ROB_PACKET;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 busy;
        logic                 complete;
        logic                 has_dest;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic [XLEN-1:0]      value;
    } ROB_ENTRY;

    typedef struct packed {
        logic     retire_valid;
        ROB_ENTRY rob_head;
        ROB_ENTRY rob_new_tail;
    } ROB_MAP_PACKET;

    typedef struct packed {
        logic                 valid;
        logic                 has_dest;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic [XLEN-1:0]      value;
    } ROB_RETIRE_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] value_a;
        logic [XLEN-1:0] value_b;
        logic            ready_a;
        logic            ready_b;
    } ROB_RS_PACKET;

    // A tag names a real entry only when it is in 1..ROB_SZ.
    function automatic logic tag_in_range(input logic [ROB_TAG_W-1:0] tag);
        return (tag != '0) && (tag <= ROB_TAG_W'(ROB_SZ));
    endfunction

    function automatic logic [ROB_PTR_W-1:0] tag_to_idx(input logic [ROB_TAG_W-1:0] tag);
        return ROB_PTR_W'(tag - ROB_TAG_W'(1));
    endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions, in-order retire (max 1/cycle).
// Latency: dispatch@N -> busy@N+1; CDB@M -> complete@M+1 -> retire_valid@M+1 at head -> head moves @M+2.
// Backpressure: rob_full from registered count; dispatch_valid while full is dropped (RS must gate it).
// Ports: clock/reset (sync, active-high); dispatch_valid+dp_packet in; cdb_packet in;
//        map_rob_packet in (operand tags, only read with forwarding); rob_map_packet, rob_full,
//        rob_retire_packet, rob_rs_packet, rob_dbg out.
// Optional feature macro: ROB_VALUE_FWD_EN (combinational operand value forwarding to the RS).
module rob
    import rob_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dispatch_valid,
    input  DP_PACKET               dp_packet,
    input  CDB_PACKET              cdb_packet,
    input  MAP_ROB_PACKET          map_rob_packet,
    output ROB_MAP_PACKET          rob_map_packet,
    output logic                   rob_full,
    output ROB_RETIRE_PACKET       rob_retire_packet,
    output ROB_RS_PACKET           rob_rs_packet,
    output ROB_ENTRY [ROB_SZ-1:0]  rob_dbg
);

    logic [ROB_PTR_W-1:0]  r_head;
    logic [ROB_PTR_W-1:0]  r_tail;
    logic [ROB_CNT_W-1:0]  r_count;
    ROB_ENTRY [ROB_SZ-1:0] r_entry;

    logic [ROB_PTR_W-1:0]  w_head_nxt;
    logic [ROB_PTR_W-1:0]  w_tail_nxt;
    logic [ROB_CNT_W-1:0]  w_count_nxt;
    ROB_ENTRY [ROB_SZ-1:0] w_entry_nxt;

    logic                  w_full;
    logic                  w_accept;
    logic                  w_retire;
    logic                  w_cdb_hit;
    logic [ROB_PTR_W-1:0]  w_cdb_idx;
    ROB_ENTRY              w_head_entry;
    ROB_ENTRY              w_new_tail;

    assign w_full       = (r_count == ROB_CNT_W'(ROB_SZ));
    assign w_accept     = dispatch_valid && !w_full;
    assign w_head_entry = r_entry[r_head];
    assign w_retire     = (r_count != '0) && w_head_entry.complete;
    assign w_cdb_idx    = tag_to_idx(cdb_packet.rob_tag);
    // Only busy entries accept a broadcast; stale or idle tags fall through.
    assign w_cdb_hit    = tag_in_range(cdb_packet.rob_tag) && r_entry[w_cdb_idx].busy;

    // Order matters: the retire clear is applied after the CDB write so an entry
    // leaving this cycle ends up free, and the dispatch write lands last (it can
    // never target the head while count is nonzero, nor a busy slot).
    always_comb begin
        w_entry_nxt = r_entry;
        if (w_cdb_hit) begin
            w_entry_nxt[w_cdb_idx].complete = 1'b1;
            w_entry_nxt[w_cdb_idx].value    = cdb_packet.value;
        end
        if (w_retire) begin
            w_entry_nxt[r_head].busy     = 1'b0;
            w_entry_nxt[r_head].complete = 1'b0;
        end
        if (w_accept) begin
            w_entry_nxt[r_tail].busy         = 1'b1;
            w_entry_nxt[r_tail].complete     = 1'b0;
            w_entry_nxt[r_tail].has_dest     = dp_packet.has_dest;
            w_entry_nxt[r_tail].dest_reg_idx = dp_packet.dest_reg_idx;
            w_entry_nxt[r_tail].value        = '0;
        end
    end

    // Pointers wrap for free because ROB_SZ is a power of two.
    always_comb begin
        w_head_nxt  = r_head + ROB_PTR_W'(w_retire);
        w_tail_nxt  = r_tail + ROB_PTR_W'(w_accept);
        w_count_nxt = r_count + ROB_CNT_W'(w_accept) - ROB_CNT_W'(w_retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                r_entry[i]         <= '0;
                r_entry[i].rob_tag <= ROB_TAG_W'(i + 1);
            end
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_entry <= w_entry_nxt;
        end
    end

    always_comb begin
        w_new_tail         = r_entry[r_tail];
        w_new_tail.rob_tag = ROB_TAG_W'(r_tail) + ROB_TAG_W'(1);
    end

    assign rob_full                    = w_full;
    assign rob_map_packet.retire_valid = w_retire;
    assign rob_map_packet.rob_head     = w_head_entry;
    assign rob_map_packet.rob_new_tail = w_new_tail;

    assign rob_retire_packet.valid        = w_retire;
    assign rob_retire_packet.has_dest     = w_head_entry.has_dest;
    assign rob_retire_packet.dest_reg_idx = w_head_entry.dest_reg_idx;
    assign rob_retire_packet.value        = w_head_entry.value;

    assign rob_dbg = r_entry;

`ifdef ROB_VALUE_FWD_EN
    // Operand values already written back (t_plus) are read straight from the
    // entry array; a result arriving on the CDB this cycle is not bypassed.
    always_comb begin
        rob_rs_packet = '0;
        if (tag_in_range(map_rob_packet.map_packet_a.rob_tag) && map_rob_packet.map_packet_a.t_plus) begin
            rob_rs_packet.value_a = r_entry[tag_to_idx(map_rob_packet.map_packet_a.rob_tag)].value;
            rob_rs_packet.ready_a = 1'b1;
        end
        if (tag_in_range(map_rob_packet.map_packet_b.rob_tag) && map_rob_packet.map_packet_b.t_plus) begin
            rob_rs_packet.value_b = r_entry[tag_to_idx(map_rob_packet.map_packet_b.rob_tag)].value;
            rob_rs_packet.ready_b = 1'b1;
        end
    end
`else
    assign rob_rs_packet = '0;
    // Map table operand tags have no consumer without forwarding.
    logic w_unused_map;
    assign w_unused_map = ^map_rob_packet;
`endif

endmodule

// File: tb/tb_rob.sv
module tb_rob;
    import rob_pkg::*;

    logic             clock;
    logic             reset;
    logic             dispatch_valid;
    DP_PACKET         dp_packet;
    CDB_PACKET        cdb_packet;
    MAP_ROB_PACKET    map_rob_packet;
    ROB_MAP_PACKET    rob_map_packet;
    logic             rob_full;
    ROB_RETIRE_PACKET rob_retire_packet;
    ROB_RS_PACKET     rob_rs_packet;
    ROB_ENTRY [ROB_SZ-1:0] rob_dbg;

    rob dut (
        .clock             (clock),
        .reset             (reset),
        .dispatch_valid    (dispatch_valid),
        .dp_packet         (dp_packet),
        .cdb_packet        (cdb_packet),
        .map_rob_packet    (map_rob_packet),
        .rob_map_packet    (rob_map_packet),
        .rob_full          (rob_full),
        .rob_retire_packet (rob_retire_packet),
        .rob_rs_packet     (rob_rs_packet),
        .rob_dbg           (rob_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: program-ordered list of in-flight instructions,
    // the next tag to hand out, and the last value written into each tag.
    typedef struct {
        int              tag;
        bit              hd;
        logic [4:0]      dr;
        bit              cmp;
        logic [31:0]     val;
    } rec_t;

    typedef struct packed {
        logic        hd;
        logic [4:0]  dr;
        logic [31:0] val;
    } ret_t;

    rec_t        mq[$];
    ret_t        exp_q[$];
    int          next_tag;
    logic [31:0] vals [1:ROB_SZ];
    int          checks;
    int          errors;
    bit          mon_en;
    MAP_ROB_PACKET mp0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit in_flight(input int tag);
        foreach (mq[i]) if (mq[i].tag == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update(input logic r, input logic dv, input logic hd, input logic [4:0] dr,
                                input logic [ROB_TAG_W-1:0] ct, input logic [31:0] cv);
        int sz;
        bit ret;
        if (r) begin
            mq.delete();
            next_tag = 1;
            for (int t = 1; t <= ROB_SZ; t++) vals[t] = '0;
            return;
        end
        sz  = mq.size();
        ret = (sz > 0) && mq[0].cmp;
        if (ct != 0) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(ct)) begin
                    mq[i].cmp = 1'b1;
                    mq[i].val = cv;
                    vals[int'(ct)] = cv;
                end
            end
        end
        if (ret) void'(mq.pop_front());
        if (dv && sz < ROB_SZ) begin
            mq.push_back('{tag: next_tag, hd: hd, dr: dr, cmp: 1'b0, val: 32'h0});
            vals[next_tag] = '0;
            next_tag = (next_tag % ROB_SZ) + 1;
        end
    endtask

    // Drive one cycle of inputs, queue the retire the model expects in this
    // cycle, then advance the model across the clock edge.
    task automatic step(input logic dv, input logic hd, input logic [4:0] dr,
                        input logic [ROB_TAG_W-1:0] ct, input logic [31:0] cv, input MAP_ROB_PACKET mp);
        logic r;
        r = reset;
        dispatch_valid         = dv;
        dp_packet.has_dest     = hd;
        dp_packet.dest_reg_idx = dr;
        cdb_packet.rob_tag     = ct;
        cdb_packet.value       = cv;
        map_rob_packet         = mp;
        if (!r && mq.size() > 0 && mq[0].cmp)
            exp_q.push_back('{hd: mq[0].hd, dr: mq[0].dr, val: mq[0].val});
        @(posedge clock);
        #1;
        model_update(r, dv, hd, dr, ct, cv);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 5'd0, '0, 32'h0, mp0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] dr);
        step(1'b1, 1'b1, dr, '0, 32'h0, mp0);
    endtask

    function automatic logic [ROB_SZ-1:0] dut_busy();
        logic [ROB_SZ-1:0] b;
        for (int i = 0; i < ROB_SZ; i++) b[i] = rob_dbg[i].busy;
        return b;
    endfunction

    task automatic drain();
        logic [ROB_TAG_W-1:0] ct;
        for (int k = 0; k < 60 && mq.size() > 0; k++) begin
            ct = '0;
            foreach (mq[i]) if (!mq[i].cmp && ct == '0) ct = ROB_TAG_W'(mq[i].tag);
            step(1'b0, 1'b0, 5'd0, ct, $urandom, mp0);
        end
        chk("drain_busy", dut_busy(), '0);
    endtask

    function automatic logic [ROB_TAG_W-1:0] pick_cdb_tag();
        int sel;
        int cands[$];
        sel = $urandom_range(0, 9);
        if (sel < 6) begin
            foreach (mq[i]) if (!mq[i].cmp) cands.push_back(mq[i].tag);
            if (cands.size() == 0) return '0;
            return ROB_TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
        end
        if (sel < 8) return '0;
        if (sel == 8) begin
            for (int t = 1; t <= ROB_SZ; t++) if (!in_flight(t)) cands.push_back(t);
            if (cands.size() == 0) return '0;
            return ROB_TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
        end
        return ROB_TAG_W'($urandom_range(ROB_SZ + 1, (1 << ROB_TAG_W) - 1));
    endfunction

    // Monitor: status, entry array and the retire scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        logic [ROB_SZ-1:0] eb, ec, ab, ac;
        logic [31:0]       ev;
        logic              er;
        ret_t              got, want;
        if (mon_en) begin
            chk("full", rob_full, (mq.size() == ROB_SZ));
            chk("new_tail_tag", rob_map_packet.rob_new_tail.rob_tag, next_tag);
            eb = '0;
            ec = '0;
            foreach (mq[i]) begin
                eb[mq[i].tag - 1] = 1'b1;
                ec[mq[i].tag - 1] = mq[i].cmp;
            end
            for (int i = 0; i < ROB_SZ; i++) begin
                ab[i] = rob_dbg[i].busy;
                ac[i] = rob_dbg[i].complete;
                chk("entry_value", rob_dbg[i].value, vals[i + 1]);
                chk("entry_tag", rob_dbg[i].rob_tag, i + 1);
            end
            chk("busy_vec", ab, eb);
            chk("complete_vec", ac, ec);
            if (!reset) begin
                chk("retire_valid", rob_map_packet.retire_valid, (mq.size() > 0 && mq[0].cmp));
                if (rob_retire_packet.valid) begin
                    got = '{hd: rob_retire_packet.has_dest, dr: rob_retire_packet.dest_reg_idx,
                            val: rob_retire_packet.value};
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", got, '0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("retire_dat", got, want);
                    end
                end else if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    chk("missing_retire", 1'b0, 1'b1);
                end
            end
`ifdef ROB_VALUE_FWD_EN
            er = (map_rob_packet.map_packet_a.rob_tag != 0) && map_rob_packet.map_packet_a.t_plus &&
                 (map_rob_packet.map_packet_a.rob_tag <= ROB_SZ);
            ev = er ? vals[int'(map_rob_packet.map_packet_a.rob_tag)] : 32'h0;
            chk("fwd_a", {rob_rs_packet.ready_a, rob_rs_packet.value_a}, {er, ev});
            er = (map_rob_packet.map_packet_b.rob_tag != 0) && map_rob_packet.map_packet_b.t_plus &&
                 (map_rob_packet.map_packet_b.rob_tag <= ROB_SZ);
            ev = er ? vals[int'(map_rob_packet.map_packet_b.rob_tag)] : 32'h0;
            chk("fwd_b", {rob_rs_packet.ready_b, rob_rs_packet.value_b}, {er, ev});
`else
            chk("rs_tied_off", rob_rs_packet, '0);
`endif
        end
    end

    initial begin
        MAP_ROB_PACKET mp;
        logic dv, hd;
        logic [4:0] dr;
        logic [ROB_TAG_W-1:0] ct;
        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        mp0      = '0;
        next_tag = 1;
        for (int t = 1; t <= ROB_SZ; t++) vals[t] = '0;
        reset          = 1'b1;
        dispatch_valid = 1'b0;
        dp_packet      = '0;
        cdb_packet     = '0;
        map_rob_packet = '0;

        // Reset then idle
        step(1'b0, 1'b0, 5'd0, '0, 32'h0, mp0);
        mon_en = 1'b1;
        do_reset();
        idle(10);
        chk("t1_new_tail", rob_map_packet.rob_new_tail.rob_tag, 1);
        chk("t1_full", rob_full, 0);

        // Out-of-order completion, in-order retire
        dispatch(5'd5);
        dispatch(5'd6);
        dispatch(5'd7);
        step(1'b0, 1'b0, 5'd0, ROB_TAG_W'(2), 32'hBEEF, mp0);
        chk("t2_tag2_complete", rob_dbg[1].complete, 1);
        chk("t2_no_retire", rob_retire_packet.valid, 0);
        step(1'b0, 1'b0, 5'd0, ROB_TAG_W'(1), 32'h11, mp0);
        chk("t2_retire_x5", {rob_retire_packet.valid, rob_retire_packet.dest_reg_idx, rob_retire_packet.value},
            {1'b1, 5'd5, 32'h11});
        idle(1);
        chk("t2_retire_x6", {rob_retire_packet.valid, rob_retire_packet.dest_reg_idx, rob_retire_packet.value},
            {1'b1, 5'd6, 32'hBEEF});
        idle(1);
        chk("t2_head3_waits", rob_retire_packet.valid, 0);
        drain();

        // Fill, overflow attempts, full+retire with dispatch
        do_reset();
        for (int i = 0; i < ROB_SZ; i++) dispatch(5'(i + 1));
        chk("t3_full", rob_full, 1);
        chk("t3_wrap_tag", rob_map_packet.rob_new_tail.rob_tag, 1);
        dispatch(5'd20);
        dispatch(5'd21);
        chk("t3_count8", dut_busy(), {ROB_SZ{1'b1}});
        step(1'b0, 1'b0, 5'd0, ROB_TAG_W'(1), 32'hA1, mp0);
        chk("t4_head_ready", {rob_full, rob_retire_packet.valid}, 2'b11);
        dispatch(5'd9);
        chk("t4_freed", {rob_full, rob_dbg[0].busy}, 2'b00);
        chk("t4_tail_tag", rob_map_packet.rob_new_tail.rob_tag, 1);
        dispatch(5'd10);
        chk("t4_new_entry", {rob_full, rob_dbg[0].busy, rob_dbg[0].dest_reg_idx}, {1'b1, 1'b1, 5'd10});
        drain();

        // Idle CDB and CDB to a free tag
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        step(1'b0, 1'b0, 5'd0, '0, 32'hDEAD, mp0);
        chk("t5_tag0", {rob_dbg[0].complete, rob_dbg[1].complete, rob_dbg[0].value}, '0);
        step(1'b0, 1'b0, 5'd0, ROB_TAG_W'(5), 32'hCAFE, mp0);
        chk("t5_free_tag", {rob_dbg[4].busy, rob_dbg[4].complete, rob_dbg[4].value}, '0);
        drain();

        // Operand forwarding
        do_reset();
        dispatch(5'd3);
        dispatch(5'd4);
        dispatch(5'd8);
        step(1'b0, 1'b0, 5'd0, ROB_TAG_W'(3), 32'h42, mp0);
        mp = '0;
        mp.map_packet_a.rob_tag = ROB_TAG_W'(3);
        mp.map_packet_a.t_plus  = 1'b1;
        step(1'b0, 1'b0, 5'd0, '0, 32'h0, mp);
`ifdef ROB_VALUE_FWD_EN
        chk("t6_fwd_a", {rob_rs_packet.ready_a, rob_rs_packet.value_a}, {1'b1, 32'h42});
`else
        chk("t6_rs_zero", rob_rs_packet, '0);
`endif
        drain();

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            dv = ($urandom_range(0, 9) < 6);
            hd = 1'($urandom);
            dr = 5'($urandom);
            ct = pick_cdb_tag();
            mp.map_packet_a.rob_tag = ROB_TAG_W'($urandom_range(0, ROB_SZ));
            mp.map_packet_a.t_plus  = 1'($urandom);
            mp.map_packet_b.rob_tag = ROB_TAG_W'($urandom_range(0, ROB_SZ));
            mp.map_packet_b.t_plus  = 1'($urandom);
            if (n == 750) reset = 1'b1;
            step(dv, hd, dr, ct, $urandom, mp);
            reset = 1'b0;
        end
        drain();
        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
